bit_plotter_trigger: RTL and testbench



---
 rtl/bit_plotter_trigger.sv | 132 +++++++++++++
 tb/tb_bit_plotter_trigger.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_plotter_trigger.sv
// Trigger front end for the bit plotter: synchronises probe and arm button,
// debounces the button, and sequences clear/arm/start with capture-window status.
module bit_plotter_trigger #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int CAPTURE_BITS  = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       probeIn,
    input  logic       armButton,
    input  logic [1:0] mode,
    output logic       start,
    output logic       clear,
    output logic       bitOut,
    output logic       armed,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, CLEARING, ARMED, RUNNING, DONE} state_t;

    state_t                   state;
    logic                     p1, p2, p3;
    logic                     b1, b2, stable, rel_seen;
    logic [1:0]               sync_vld;
    logic [DEBOUNCE_BITS-1:0] dcnt;
    logic [CAPTURE_BITS-1:0]  ccnt;
    logic                     rise, fall, trig, accept, press;

    assign bitOut = p3;
    assign rise   = p2 & ~p3;
    assign fall   = ~p2 & p3;

    always_comb begin
        trig = 1'b0;
        case (mode)
            2'd0:    trig = rise;
            2'd1:    trig = fall;
            2'd2:    trig = rise | fall;
            default: trig = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
            p3 <= 1'b0;
        end else begin
            p1 <= probeIn;
            p2 <= p1;
            p3 <= p2;
        end
    end

    // A button held through reset must be seen released (once the synchroniser
    // holds real data) before its next rising acceptance counts as a press.
    assign accept = (b2 != stable) && (&dcnt);
    assign press  = accept && b2 && rel_seen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b1       <= 1'b0;
            b2       <= 1'b0;
            stable   <= 1'b0;
            rel_seen <= 1'b0;
            sync_vld <= 2'b00;
            dcnt     <= '0;
        end else begin
            b1       <= armButton;
            b2       <= b1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && !b2)
                rel_seen <= 1'b1;
            if (b2 == stable)
                dcnt <= '0;
            else if (&dcnt) begin
                stable <= b2;
                dcnt   <= '0;
            end else
                dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ccnt  <= '0;
            start <= 1'b0;
            clear <= 1'b0;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (press) begin
            state <= CLEARING;
            start <= 1'b0;
            clear <= 1'b1;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            start <= 1'b0;
            clear <= 1'b0;
            case (state)
                IDLE: ;
                CLEARING: begin
                    state <= ARMED;
                    armed <= 1'b1;
                end
                ARMED: if (trig) begin
                    state <= RUNNING;
                    armed <= 1'b0;
                    busy  <= 1'b1;
                    start <= 1'b1;
                    ccnt  <= '0;
                end
                RUNNING: if (&ccnt) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else
                    ccnt <= ccnt + 1'b1;
                DONE: ;
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_plotter_trigger.sv
// Bench for bit_plotter_trigger: directed vector table, hand sequences and
// randomized stimulus, all checked against a sample-history reference model.
module tb_bit_plotter_trigger;
    localparam int DB = 2, CB = 4;
    localparam int DB_LEN = 1 << DB, CAP_LEN = 1 << CB;

    logic       clk = 1'b0, reset = 1'b1, probeIn = 1'b0, armButton = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       start, clear, bitOut, armed, busy, done;
    int         total = 0, bad = 0;
    int         n_start = 0, n_clear = 0;

    bit_plotter_trigger #(.DEBOUNCE_BITS(DB), .CAPTURE_BITS(CB)) dut (
        .clk(clk), .reset(reset), .probeIn(probeIn), .armButton(armButton),
        .mode(mode), .start(start), .clear(clear), .bitOut(bitOut),
        .armed(armed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample histories, a window test for debounce,
    // and a phase with a remaining-cycles count for the capture window.
    typedef enum {M_IDLE, M_CLR, M_ARM, M_RUN, M_DONE} mph_t;
    mph_t ph = M_IDLE;
    int   rem = 0;
    bit   rel = 0, stab = 0, mstart = 0;
    bit   pq[$], bq[$], xq[$];

    function automatic bit pat(int k);
        return (pq.size() > k) ? pq[pq.size()-1-k] : 1'b0;
    endfunction

    function automatic logic [5:0] expv();
        return {mstart, ph == M_CLR, pat(2), ph == M_ARM, ph == M_RUN, ph == M_DONE};
    endfunction

    task automatic model_reset();
        ph = M_IDLE; rem = 0; rel = 0; stab = 0; mstart = 0;
        pq.delete(); bq.delete(); xq.delete();
    endtask

    task automatic model_step();
        bit x, xv, nw, od, trg, accept, press;
        pq.push_back(probeIn);
        bq.push_back(armButton);
        if (pq.size() > 8) pq.delete(0);
        if (bq.size() > 8) bq.delete(0);
        xv = bq.size() > 2;
        x  = xv ? bq[bq.size()-3] : 1'b0;
        xq.push_back(x);
        if (xq.size() > DB_LEN) xq.delete(0);
        accept = (xq.size() == DB_LEN);
        foreach (xq[i]) if (xq[i] == stab) accept = 0;
        press = accept && !stab && rel;
        if (accept) begin
            stab = !stab;
            xq.delete();
        end
        if (xv && !x) rel = 1;
        nw = pat(2);
        od = pat(3);
        case (mode)
            2'd0:    trg = nw && !od;
            2'd1:    trg = !nw && od;
            2'd2:    trg = nw != od;
            default: trg = 1;
        endcase
        mstart = 0;
        if (press) ph = M_CLR;
        else case (ph)
            M_CLR: ph = M_ARM;
            M_ARM: if (trg) begin ph = M_RUN; rem = CAP_LEN; mstart = 1; end
            M_RUN: begin rem--; if (rem == 0) ph = M_DONE; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (start,clear,bitOut,armed,busy,done)", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        chk("cycle", {start, clear, bitOut, armed, busy, done}, expv());
        if (start) n_start++;
        if (clear) n_clear++;
    endtask

    task automatic pulse_reset();
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset", {start, clear, bitOut, armed, busy, done}, 6'b0);
        tick();
        tick();
        #3 reset = 1'b0;
    endtask

    typedef struct {
        logic       probe;
        logic       btn;
        logic [1:0] mode;
        int         ncyc;
        logic [2:0] stat;    // {armed, busy, done} after the segment
        int         starts;
        int         clears;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic p, input logic b, input logic [1:0] m, input int n,
                       input logic [2:0] st, input int s, input int c);
        vec_t v;
        v.probe = p; v.btn = b; v.mode = m; v.ncyc = n;
        v.stat = st; v.starts = s; v.clears = c;
        tbl.push_back(v);
    endtask

    initial begin
        int hold = 0;
        // arm, rising trigger, 16-cycle window, done
        add(0, 1, 0,  7, 3'b100, 0, 1);
        add(0, 1, 0,  3, 3'b100, 0, 0);
        add(1, 1, 0,  3, 3'b010, 1, 0);
        add(1, 1, 0, 15, 3'b010, 0, 0);
        add(1, 1, 0,  1, 3'b001, 0, 0);
        add(0, 1, 0,  6, 3'b001, 0, 0);
        // re-arm in falling mode; a rise must not trigger
        add(0, 0, 0,  6, 3'b001, 0, 0);
        add(0, 1, 1,  7, 3'b100, 0, 1);
        add(1, 1, 1,  4, 3'b100, 0, 0);
        add(0, 1, 1,  3, 3'b010, 1, 0);
        // abort mid-capture
        add(0, 0, 1,  4, 3'b010, 0, 0);
        add(0, 1, 1,  6, 3'b000, 0, 1);
        add(0, 1, 1,  1, 3'b100, 0, 0);
        // press and trigger edge in the same cycle: press wins
        add(0, 0, 1,  6, 3'b100, 0, 0);
        add(0, 1, 2,  3, 3'b100, 0, 0);
        add(1, 1, 2,  3, 3'b000, 0, 1);
        add(1, 1, 2,  4, 3'b100, 0, 0);
        // either-edge mode: falling then rising
        add(0, 1, 2,  3, 3'b010, 1, 0);
        add(0, 1, 2, 16, 3'b001, 0, 0);
        add(0, 0, 2,  6, 3'b001, 0, 0);
        add(0, 1, 2,  7, 3'b100, 0, 1);
        add(1, 1, 2,  3, 3'b010, 1, 0);
        add(1, 1, 2, 16, 3'b001, 0, 0);
        // immediate mode with a constant probe
        add(1, 0, 2,  6, 3'b001, 0, 0);
        add(1, 1, 3,  6, 3'b000, 0, 1);
        add(1, 1, 3,  1, 3'b100, 0, 0);
        add(1, 1, 3,  1, 3'b010, 1, 0);
        add(1, 1, 3,  5, 3'b010, 0, 0);

        // reset held while the probe toggles
        for (int i = 0; i < 6; i++) begin
            probeIn = i[0];
            tick();
        end
        chk("reset_idle", {start, clear, bitOut, armed, busy, done}, 6'b0);
        #3 reset = 1'b0;
        probeIn = 1'b0;
        repeat (4) tick();
        probeIn = 1'b1;
        repeat (2) tick();
        chk("bitout_lat2", {5'b0, bitOut}, 6'b0);
        tick();
        chk("bitout_lat3", {5'b0, bitOut}, 6'b1);
        probeIn = 1'b0;
        repeat (3) tick();

        // bouncing button: toggles every 2 cycles, never accepted
        n_clear = 0;
        for (int i = 0; i < 20; i++) begin
            armButton = ((i / 2) % 2) == 0;
            tick();
        end
        chk_i("bounce_clears", n_clear, 0);
        chk("bounce_status", {3'b0, armed, busy, done}, 6'b0);

        foreach (tbl[i]) begin
            probeIn = tbl[i].probe;
            armButton = tbl[i].btn;
            mode = tbl[i].mode;
            n_start = 0;
            n_clear = 0;
            repeat (tbl[i].ncyc) tick();
            chk($sformatf("vec%0d_status", i), {3'b0, armed, busy, done}, {3'b0, tbl[i].stat});
            chk_i($sformatf("vec%0d_starts", i), n_start, tbl[i].starts);
            chk_i($sformatf("vec%0d_clears", i), n_clear, tbl[i].clears);
        end

        // async reset mid-capture with the button held through it
        pulse_reset();
        n_clear = 0;
        repeat (12) tick();
        chk_i("held_no_clear", n_clear, 0);
        chk("held_no_arm", {3'b0, armed, busy, done}, 6'b0);
        armButton = 1'b0;
        repeat (6) tick();
        armButton = 1'b1;
        repeat (7) tick();
        chk_i("rearm_clears", n_clear, 1);
        chk("rearm_status", {3'b0, armed, busy, done}, 6'b000100);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) probeIn = $urandom_range(0, 1);
            if (hold == 0) begin
                armButton = $urandom_range(0, 1);
                hold = $urandom_range(1, ($urandom_range(0, 1) == 1) ? 6 : 40);
            end
            hold--;
            if ($urandom_range(0, 40) == 0) mode = $urandom_range(0, 3);
            if ($urandom_range(0, 500) == 0) pulse_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
